// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// A zero divisor completes immediately with quotient all ones and remainder = dividend.
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_quo;

  // The partial remainder is always below the divisor, so shifted < 2*divisor and
  // the MSB of the (WIDTH+1)-bit difference is exactly the borrow.
  assign shifted  = {part_rem, quo_sh[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvsr};
  assign fits     = ~trial[WIDTH];
  assign next_rem = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign next_quo = {quo_sh[WIDTH-2:0], fits};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      part_rem    <= '0;
      quo_sh      <= '0;
      dvsr        <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              quo_sh      <= dividend;
              dvsr        <= divisor;
              part_rem    <= '0;
              count       <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          part_rem <= next_rem;
          quo_sh   <= next_quo;
          count    <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            quotient  <= next_quo;
            remainder <= next_rem;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
